counter_updown_limit: RTL and testbench
=======================================

Name: counter_updown_limit

Overview:
- Parametrised successor to the team's fixed up/down counter.
- Adds generic width, runtime upper limit, direction control, enable, synchronous load, and selectable wrap/saturate mode.
- Adds a terminal-count flag and registered overflow/underflow pulses.
- Used as a general event/timer counter in datapath and control blocks.

Parameters:
- WIDTH, 4, counter width in bits (>=2).
- RST_VAL, 0, value of count after reset. Must be <= 2^WIDTH-1.
- SAT_MODE, 0, boundary mode: 0 = wrap-around, 1 = saturate (hold at limit).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- en  input  1  count enable; one step per clk edge while high.
- up_dn  input  1  direction: 1 = count up, 0 = count down.
- load  input  1  synchronous load strobe.
- load_val  input  WIDTH  value loaded when load=1.
- max_val  input  WIDTH  runtime upper limit; legal count range is 0..max_val.
- count  output  WIDTH  registered counter value.
- tc  output  1  terminal count, combinational: (up_dn=1 and count==max_val) or (up_dn=0 and count==0).
- ovf  output  1  registered one-cycle pulse: an up step hit the upper boundary.
- unf  output  1  registered one-cycle pulse: a down step hit zero.

Behaviour:
- Reset (reset=0, async): count=RST_VAL, ovf=0, unf=0, effective immediately, independent of clk. Mid-operation reset aborts any step; first update happens on the first rising clk after reset returns high.
- Update priority each rising clk: load > en > hold.
- Load (load=1): count <= min(load_val, max_val). ovf=unf=0. en is ignored that cycle.
- Out-of-range (en=1, load=0, count > max_val, e.g. after max_val was lowered): count <= max_val in either direction. No ovf/unf.
- Up step (en=1, up_dn=1, count < max_val): count <= count+1.
- Up boundary (en=1, up_dn=1, count == max_val): ovf=1 for exactly that cycle.
  - SAT_MODE=0: count <= 0.
  - SAT_MODE=1: count holds.
- Down step (en=1, up_dn=0, count > 0): count <= count-1.
- Down boundary (en=1, up_dn=0, count == 0): unf=1 for exactly that cycle.
  - SAT_MODE=0: count <= max_val.
  - SAT_MODE=1: count holds at 0.
- ovf and unf are never both 1. Both are 0 in every cycle not listed above, including hold, load and the out-of-range correction.
- max_val == 0: the counter stays at 0. Every enabled step raises ovf (up) or unf (down).
- Latency: count, ovf and unf reflect inputs sampled at edge N immediately after edge N. tc has zero latency and follows count and up_dn combinationally.
- Arithmetic is unsigned WIDTH-bit. No carry out beyond ovf/unf. max_val = 2^WIDTH-1 gives natural modulo-2^WIDTH behaviour.
- up_dn may change on any cycle. The new direction applies to the next enabled edge.

Test Plan:
- Reset: WIDTH=3, RST_VAL=0, drive reset=0 mid-count at count=5 between clock edges -> count=0, ovf=unf=0 immediately without a clk edge. Hold reset=1 with en=0 -> count stays 0.
- Wrap up: WIDTH=3, SAT_MODE=0, max_val=5, en=1, up_dn=1, 8 edges -> count 1,2,3,4,5,0,1,2. ovf=1 only on the edge producing 0. tc=1 while count=5.
- Wrap down / saturate: SAT_MODE=0, max_val=5, up_dn=0 from 0 -> count 5, ovf=0, unf=1 for one cycle. SAT_MODE=1, max_val=7, up from 6 -> 7,7,7 with ovf=1 on each edge at 7.
- Load priority and clamp: max_val=4, load=1, load_val=6, en=1 -> count=4, ovf=0. Next cycle load=0, en=1, up -> count=0 (wrap mode), ovf=1.
- Limit lowered: count=6, max_val changed to 3, en=1, up_dn=0 -> count=3, unf=0. Next edge -> count=2.
- Enable gating / full range: en=0 for 5 edges -> count unchanged, ovf=unf=0. WIDTH=3, max_val=7, up from 7 -> count 0 with ovf=1.

Source files
------------

// File: rtl/counter_updown_limit.sv
// Up/down event counter with a runtime upper limit, synchronous load, wrap or
// saturate boundary handling, a combinational terminal-count flag and registered
// overflow/underflow pulses.
module counter_updown_limit #(
  parameter int WIDTH    = 4,
  parameter int RST_VAL  = 0,
  parameter int SAT_MODE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] max_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf,
  output logic             unf
);

  localparam logic [WIDTH-1:0] RST_COUNT = WIDTH'(RST_VAL);
  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);
  localparam bit               SATURATE  = (SAT_MODE != 0);

  logic [WIDTH-1:0] count_nxt;
  logic             ovf_nxt;
  logic             unf_nxt;

  // NOTE: every output of this block is given a default before any branch, so no
  // path can leave a value unassigned and infer a latch.
  always_comb begin
    count_nxt = count;
    ovf_nxt   = 1'b0;
    unf_nxt   = 1'b0;
    if (load) begin
      count_nxt = (load_val > max_val) ? max_val : load_val;
    end else if (en) begin
      if (count > max_val) begin
        // Limit was lowered under us: snap back into range without a pulse.
        count_nxt = max_val;
      end else if (up_dn) begin
        if (count == max_val) begin
          ovf_nxt   = 1'b1;
          count_nxt = SATURATE ? count : '0;
        end else begin
          count_nxt = count + ONE;
        end
      end else begin
        if (count == '0) begin
          unf_nxt   = 1'b1;
          count_nxt = SATURATE ? '0 : max_val;
        end else begin
          count_nxt = count - ONE;
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= RST_COUNT;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else begin
      count <= count_nxt;
      ovf   <= ovf_nxt;
      unf   <= unf_nxt;
    end
  end

  assign tc = up_dn ? (count == max_val) : (count == '0);

endmodule

// File: tb/tb_counter_updown_limit.sv
// Checks a wrap-mode and a saturate-mode 3-bit counter side by side against an
// arithmetic reference model, with directed boundary steps then random traffic.
module tb_counter_updown_limit;

  logic       clk = 1'b0;
  logic       reset;
  logic       en, up_dn, load;
  logic [2:0] load_val, max_val;

  logic [2:0] cnt_w, cnt_s;
  logic       tc_w, tc_s, ovf_w, ovf_s, unf_w, unf_s;

  int checks = 0;
  int errors = 0;

  // Reference state: index 0 = wrap instance, index 1 = saturate instance.
  int m_cnt [2];
  bit m_ovf [2];
  bit m_unf [2];

  counter_updown_limit #(.WIDTH(3), .RST_VAL(0), .SAT_MODE(0)) dut_w (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .max_val(max_val),
    .count(cnt_w), .tc(tc_w), .ovf(ovf_w), .unf(unf_w)
  );

  counter_updown_limit #(.WIDTH(3), .RST_VAL(0), .SAT_MODE(1)) dut_s (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .max_val(max_val),
    .count(cnt_s), .tc(tc_s), .ovf(ovf_s), .unf(unf_s)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_cnt[i] = 0;
      m_ovf[i] = 1'b0;
      m_unf[i] = 1'b0;
    end
  endtask

  // One rising edge worth of behaviour, from the counting rules in plain arithmetic.
  function automatic void model_edge();
    for (int i = 0; i < 2; i++) begin
      int c;
      int mx;
      bit sat;
      c   = m_cnt[i];
      mx  = int'(max_val);
      sat = (i == 1);
      m_ovf[i] = 1'b0;
      m_unf[i] = 1'b0;
      if (load) begin
        m_cnt[i] = (int'(load_val) < mx) ? int'(load_val) : mx;
      end else if (en) begin
        if (c > mx) begin
          m_cnt[i] = mx;
        end else if (up_dn) begin
          m_ovf[i] = (c == mx);
          m_cnt[i] = sat ? ((c + 1 > mx) ? mx : c + 1) : (c + 1) % (mx + 1);
        end else begin
          m_unf[i] = (c == 0);
          m_cnt[i] = sat ? ((c == 0) ? 0 : c - 1) : (c + mx) % (mx + 1);
        end
      end
    end
  endfunction

  function automatic int model_tc(input int i);
    return up_dn ? int'(m_cnt[i] == int'(max_val)) : int'(m_cnt[i] == 0);
  endfunction

  task automatic check_all(input string tag);
    chk({tag, " w.count"}, 32'(cnt_w), m_cnt[0]);
    chk({tag, " w.ovf"},   32'(ovf_w), 32'(m_ovf[0]));
    chk({tag, " w.unf"},   32'(unf_w), 32'(m_unf[0]));
    chk({tag, " w.tc"},    32'(tc_w),  model_tc(0));
    chk({tag, " s.count"}, 32'(cnt_s), m_cnt[1]);
    chk({tag, " s.ovf"},   32'(ovf_s), 32'(m_ovf[1]));
    chk({tag, " s.unf"},   32'(unf_s), 32'(m_unf[1]));
    chk({tag, " s.tc"},    32'(tc_s),  model_tc(1));
  endtask

  // Inputs are already set; take one edge and check 1 ns later.
  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  // Called 1 ns after an edge: pulse reset between edges and check it acts at once.
  task automatic async_reset(input string tag);
    #2 reset = 1'b0;
    model_reset();
    #1 check_all(tag);
    #2 reset = 1'b1;
  endtask

  int exp_seq [8] = '{1, 2, 3, 4, 5, 0, 1, 2};

  initial begin
    reset = 1'b0; en = 1'b1; up_dn = 1'b1; load = 1'b0;
    load_val = 3'd0; max_val = 3'd5;
    model_reset();
    #3 check_all("reset_state");
    @(posedge clk); #1;
    check_all("reset_held_over_edge");
    reset = 1'b1;

    // Wrap up through a limit of 5.
    for (int i = 0; i < 8; i++) begin
      step("wrap_up");
      chk("wrap_up_seq", 32'(cnt_w), exp_seq[i]);
    end
    step("to_3"); step("to_4"); step("to_5");
    chk("pre_reset_count", 32'(cnt_w), 5);

    // Mid-count asynchronous reset, then idle with reset released.
    async_reset("mid_reset");
    chk("mid_reset_count", 32'(cnt_w), 0);
    en = 1'b0;
    step("idle_after_reset"); step("idle_after_reset");

    // Wrap down from 0, then one ordinary down step.
    en = 1'b1; up_dn = 1'b0;
    step("wrap_down");
    chk("wrap_down_count", 32'(cnt_w), 5);
    chk("wrap_down_unf", 32'(unf_w), 1);
    step("down_after_wrap");

    // Saturate at the full-range limit from 6.
    max_val = 3'd7; load = 1'b1; load_val = 3'd6;
    step("load_6");
    load = 1'b0; up_dn = 1'b1;
    step("sat_up_7"); step("sat_hold_7"); step("sat_hold_7b");
    chk("sat_count", 32'(cnt_s), 7);
    chk("sat_ovf", 32'(ovf_s), 1);

    // Load beats enable and is clamped to the limit.
    max_val = 3'd4; load = 1'b1; load_val = 3'd6; en = 1'b1;
    step("load_clamp");
    chk("load_clamp_count", 32'(cnt_w), 4);
    load = 1'b0;
    step("wrap_after_load");
    chk("wrap_after_load_ovf", 32'(ovf_w), 1);

    // Limit lowered below the current count.
    max_val = 3'd7; load = 1'b1; load_val = 3'd6;
    step("load_6b");
    load = 1'b0; max_val = 3'd3; up_dn = 1'b0;
    step("limit_lowered");
    chk("limit_lowered_count", 32'(cnt_w), 3);
    step("after_lowered");

    // Enable gating.
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      up_dn = 1'(i);
      step("en_gated");
    end

    // Full-range natural wrap from 7.
    max_val = 3'd7; load = 1'b1; load_val = 3'd7;
    step("load_7");
    load = 1'b0; en = 1'b1; up_dn = 1'b1;
    step("full_wrap");
    chk("full_wrap_count", 32'(cnt_w), 0);

    // Zero limit: always at 0, every enabled step pulses.
    max_val = 3'd0;
    step("zero_lim_fix"); step("zero_lim_up");
    up_dn = 1'b0;
    step("zero_lim_down");

    // Random traffic.
    max_val = 3'd5;
    for (int i = 0; i < 400; i++) begin
      en       = ($urandom_range(0, 3) != 0);
      up_dn    = 1'($urandom_range(0, 1));
      load     = ($urandom_range(0, 9) == 0);
      load_val = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 15) == 0) max_val = 3'($urandom_range(0, 7));
      step("random");
      if ($urandom_range(0, 63) == 0) async_reset("random_reset");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
